// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory access sequencer between the datapath bus and a single-port
//   synchronous RAM with a one-cycle registered read. Holds the memory
//   address register (MAR) and memory data register (MDR). It accepts
//   one-cycle read/write requests, strobes the RAM, captures read data into
//   MDR and reports completion with a one-cycle done pulse.
//
//   Optional feature macro: MEM_FAULT_EN
//     defined   : a request with addr_in > MEM_TOP skips the RAM, goes
//                 straight to DONE and raises fault in that DONE cycle.
//     undefined : every address is legal and fault is constant 0.
//
// Ports
//   clock      in   system clock, all state changes on posedge
//   clear      in   synchronous active-high reset
//   rd_req     in   read request, sampled only in IDLE
//   wr_req     in   write request, sampled only in IDLE (wins over rd_req)
//   addr_in    in   address latched into MAR on an accepted request
//   wdata_in   in   write data latched into MDR on a write or mdr_ld
//   mdr_ld     in   direct bus load of MDR, honoured in IDLE with no request
//   busy       out  high from the cycle after acceptance until DONE exits
//   done       out  one-cycle completion pulse
//   mdr_out    out  current MDR contents
//   ram_read   out  RAM read strobe
//   ram_write  out  RAM write strobe
//   ram_addr   out  RAM address (MAR)
//   ram_wdata  out  RAM write data (MDR)
//   ram_rdata  in   RAM registered read data
//   fault      out  out-of-range access flag
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MEM_TOP = 511
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mdr_ld,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              fault
);

`ifdef MEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  // Compare one bit wider than the address so a MEM_TOP equal to the full
  // address range is an ordinary value, not the all-ones corner.
  localparam logic [ADDR_W:0] TOP_EXT = (ADDR_W+1)'(MEM_TOP);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAP,
    WR_ISSUE,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              fault_q;
  logic              addr_bad;

  // With the feature disabled FAULT_EN folds this to a constant 0, so the
  // fault flag and the skip-to-DONE path vanish.
  assign addr_bad = FAULT_EN && ({1'b0, addr_in} > TOP_EXT);

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      mar     <= '0;
      mdr     <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            mar     <= addr_in;
            mdr     <= wdata_in;
            fault_q <= addr_bad;
            state   <= addr_bad ? DONE : WR_ISSUE;
          end else if (rd_req) begin
            mar     <= addr_in;
            fault_q <= addr_bad;
            state   <= addr_bad ? DONE : RD_ISSUE;
          end else if (mdr_ld) begin
            mdr <= wdata_in;
          end
        end
        // RAM samples MAR at the edge closing this cycle.
        RD_ISSUE: state <= RD_CAP;
        // Registered RAM output is valid during this cycle.
        RD_CAP: begin
          mdr   <= ram_rdata;
          state <= DONE;
        end
        WR_ISSUE: state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Strobes and handshake decode from the state register only.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ram_read  = (state == RD_ISSUE);
  assign ram_write = (state == WR_ISSUE);
  assign fault     = fault_q;

  assign mdr_out   = mdr;
  assign ram_addr  = mar;
  assign ram_wdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
`ifdef MEM_FAULT_EN
  localparam int TOP = 255;
`else
  localparam int TOP = 511;
`endif

  logic              clock = 1'b0;
  logic              clear;
  logic              rd_req, wr_req, mdr_ld;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy, done, ram_read, ram_write, fault;
  logic [DATA_W-1:0] mdr_out, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;

  always #5 clock = ~clock;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TOP(TOP)) dut (
    .clock(clock), .clear(clear), .rd_req(rd_req), .wr_req(wr_req),
    .addr_in(addr_in), .wdata_in(wdata_in), .mdr_ld(mdr_ld),
    .busy(busy), .done(done), .mdr_out(mdr_out),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fault(fault)
  );

  // RAM device attached to the controller: 512 x 32, registered read.
  logic [DATA_W-1:0] ram [0:511];
  always @(posedge clock) begin
    if (ram_write) ram[ram_addr] <= ram_wdata;
    if (ram_read)  ram_rdata     <= ram[ram_addr];
  end

  // Reference model: expected memory image and expected MDR value.
  logic [DATA_W-1:0] ref_mem [0:511];
  logic [DATA_W-1:0] exp_mdr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [ADDR_W-1:0] a);
    return int'(a) > TOP;
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One request issued at a negedge; observed for five cycles afterwards.
  task automatic op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d, input bit noise);
    bit is_wr, is_rd, bad, both, addr_ok, wdata_ok, busy_ok;
    int exp_done_at, rdc, wrc, donec, done_at;
    logic fault_seen;
    logic [DATA_W-1:0] mdr_at_done;
    is_wr = wr;
    is_rd = rd && !wr;
    bad = is_bad(a);
    exp_done_at = bad ? 1 : (is_wr ? 2 : 3);
    rdc = 0; wrc = 0; donec = 0; done_at = -1;
    both = 0; addr_ok = 1; wdata_ok = 1; busy_ok = 1;
    fault_seen = 1'bx; mdr_at_done = 'x;
    if (is_wr) begin
      exp_mdr = d;
      if (!bad) ref_mem[a] = d;
    end else if (is_rd && !bad) begin
      exp_mdr = ref_mem[a];
    end
    rd_req = rd; wr_req = wr; addr_in = a; wdata_in = d;
    tick();
    rd_req = 0; wr_req = 0; addr_in = ADDR_W'($urandom); wdata_in = $urandom;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      if (ram_read) begin
        rdc++;
        if (ram_addr !== a) addr_ok = 0;
      end
      if (ram_write) begin
        wrc++;
        if (ram_addr !== a) addr_ok = 0;
        if (ram_wdata !== d) wdata_ok = 0;
      end
      if (ram_read && ram_write) both = 1;
      if (busy !== (k <= exp_done_at)) busy_ok = 0;
      if (done) begin
        donec++;
        done_at = k;
        fault_seen = fault;
        mdr_at_done = mdr_out;
      end
      if (noise && k == 1) begin
        wr_req = 1; mdr_ld = 1; wdata_in = ~d; addr_in = a ^ 9'h1;
      end else if (noise && k == 2) begin
        wr_req = 0; mdr_ld = 0;
      end
    end
    chk("rd_strobes", rdc, (is_rd && !bad) ? 1 : 0);
    chk("wr_strobes", wrc, (is_wr && !bad) ? 1 : 0);
    chk("strobe_addr", addr_ok, 1);
    chk("strobe_wdata", wdata_ok, 1);
    chk("strobes_exclusive", both, 0);
    chk("busy_window", busy_ok, 1);
    chk("done_count", donec, 1);
    chk("done_latency", done_at, exp_done_at);
    chk("fault_at_done", fault_seen, bad);
    chk("mdr_at_done", mdr_at_done, exp_mdr);
    chk("mdr_hold", mdr_out, exp_mdr);
  endtask

  initial begin
    int rdc, wrc, donec;
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 512; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    ram[95] = 32'h4;
    ref_mem[95] = 32'h4;
    ram_rdata = '0;

    // Reset with requests asserted
    clear = 1; rd_req = 1; wr_req = 1; mdr_ld = 1;
    addr_in = 9'd17; wdata_in = 32'hDEAD;
    @(negedge clock);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mdr", mdr_out, 0);
    chk("rst_addr", ram_addr, 0);
    clear = 0; rd_req = 0; wr_req = 0; mdr_ld = 0;
    exp_mdr = '0;
    tick();
    chk("post_rst_idle", busy, 0);

    // Directed accesses
    op(1, 0, 9'd95, 32'h0, 0);
    op(0, 1, 9'd87, 32'hABBA, 0);
    op(1, 0, 9'd87, 32'h0, 0);
    op(1, 1, 9'd42, 32'h55, 0);
    op(1, 0, 9'd42, 32'h0, 1);
    op(0, 1, 9'd511, 32'hFFFF_FFFF, 0);
    op(1, 0, 9'd0, 32'h0, 0);
    op(1, 0, 9'd300, 32'h0, 0);

    // mdr_ld in IDLE loads MDR without a done
    mdr_ld = 1; wdata_in = 32'h1234_5678;
    tick();
    mdr_ld = 0;
    exp_mdr = 32'h1234_5678;
    chk("mdr_ld_value", mdr_out, exp_mdr);
    chk("mdr_ld_no_done", done, 0);
    chk("mdr_ld_not_busy", busy, 0);

    // Held read request: two reads in eight cycles
    rd_req = 1; addr_in = 9'd95;
    rdc = 0; donec = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ram_read) rdc++;
      if (done) begin
        donec++;
        chk("held_rd_mdr", mdr_out, ref_mem[95]);
      end
    end
    rd_req = 0;
    exp_mdr = ref_mem[95];
    chk("held_rd_strobes", rdc, 2);
    chk("held_rd_dones", donec, 2);

    // Held write request: two writes in six cycles
    wr_req = 1; addr_in = 9'd60; wdata_in = 32'hCAFE;
    wrc = 0; donec = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (ram_write) wrc++;
      if (done) donec++;
    end
    wr_req = 0;
    exp_mdr = 32'hCAFE;
    ref_mem[60] = 32'hCAFE;
    chk("held_wr_strobes", wrc, 2);
    chk("held_wr_dones", donec, 2);
    op(1, 0, 9'd60, 32'h0, 0);

    // Reset in the middle of a read abandons it
    rd_req = 1; addr_in = 9'd87;
    tick();
    rd_req = 0;
    chk("abort_strobe_on", ram_read, 1);
    clear = 1;
    tick();
    clear = 0;
    exp_mdr = '0;
    chk("abort_strobe_off", ram_read, 0);
    chk("abort_busy", busy, 0);
    chk("abort_mdr", mdr_out, 0);
    chk("abort_addr", ram_addr, 0);
    donec = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) donec++;
      tick();
    end
    chk("abort_no_done", donec, 0);

    // Randomized accesses over a small address pool to get read-after-write hits
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(40, 47));
      op(kind != 1, kind != 0, ra, $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
